// File: rtl/vin_tc_spi_multi_if.sv
// Signal bundle between the multi-channel thermocouple poller, its converters and the register map.
interface vin_tc_spi_multi_if #(
    parameter int CHANNELS = 4
);
    logic                   spi_miso;
    logic                   spi_sclk;
    logic [CHANNELS-1:0]    spi_cs;
    logic [32*CHANNELS-1:0] temperature;
    logic [CHANNELS-1:0]    fault;
    logic [CHANNELS-1:0]    valid;
    logic                   busy;

    modport master (
        input  spi_miso,
        output spi_sclk, spi_cs, temperature, fault, valid, busy
    );

    modport slave (
        output spi_miso,
        input  spi_sclk, spi_cs, temperature, fault, valid, busy
    );
endinterface

// File: rtl/vin_tc_spi_multi.sv
// Round-robin poller for MAX6675 / MAX31855 converters sharing SCLK and MISO,
// one chip-select each; all timing is derived from a clk-domain tick enable.
module vin_tc_spi_multi #(
    parameter int CHANNELS   = 4,
    parameter int DIVIDER    = 1000,
    parameter int FRAME_BITS = 16,
    parameter int INTERVAL   = 100000
) (
    input logic                clk,
    input logic                rst,
    vin_tc_spi_multi_if.master bus
);
    localparam int TW = $clog2(DIVIDER);
    localparam int IW = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, SHIFT_HI, SHIFT_LO, DONE, GAP} state_t;

    state_t                state, state_n;
    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [CW-1:0]         ch, ch_n;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic [FRAME_BITS-1:0] shift, shift_n;
    logic [IW-1:0]         idle_cnt, idle_n;
    logic                  sclk, sclk_n;
    logic [CHANNELS-1:0]   cs, cs_n;
    logic                  busy, busy_n;
    logic                  finish;
    logic [CHANNELS-1:0]   sel;
    logic [31:0]           dec_raw;
    logic                  dec_fault;
    logic [32*CHANNELS-1:0] temperature;
    logic [CHANNELS-1:0]   fault;
    logic [CHANNELS-1:0]   valid;

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $fatal(1, "vin_tc_spi_multi: CHANNELS must be 1..8");
    end
    if (DIVIDER < 2) begin : g_bad_divider
        $fatal(1, "vin_tc_spi_multi: DIVIDER must be >= 2");
    end

    if (FRAME_BITS == 16) begin : g_max6675
        assign dec_raw   = {19'd0, shift[15:3]};
        assign dec_fault = shift[2];
    end else if (FRAME_BITS == 32) begin : g_max31855
        assign dec_raw   = {{18{shift[31]}}, shift[31:18]};
        assign dec_fault = shift[16];
    end else begin : g_bad_frame
        $fatal(1, "vin_tc_spi_multi: FRAME_BITS must be 16 or 32");
    end

    assign tick = (tick_cnt == '0);
    assign sel  = CHANNELS'(1) << ch;

    // Each state's listed actions are applied on the tick that enters it.
    always_comb begin
        state_n = state;
        ch_n    = ch;
        bit_n   = bit_cnt;
        shift_n = shift;
        idle_n  = idle_cnt;
        sclk_n  = sclk;
        cs_n    = cs;
        busy_n  = busy;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (idle_cnt == '0) begin
                    state_n = SELECT;
                    cs_n    = ~sel;
                    sclk_n  = 1'b0;
                    bit_n   = '0;
                    busy_n  = 1'b1;
                end else begin
                    idle_n = idle_cnt - 1'b1;
                end
            end
            SELECT: begin
                state_n = SHIFT_HI;
                sclk_n  = 1'b1;
                shift_n = {shift[FRAME_BITS-2:0], bus.spi_miso};
            end
            SHIFT_HI: begin
                state_n = SHIFT_LO;
                sclk_n  = 1'b0;
                bit_n   = bit_cnt + 1'b1;
            end
            SHIFT_LO: begin
                if (bit_cnt == BW'(FRAME_BITS)) begin
                    state_n = DONE;
                    cs_n    = '1;
                    busy_n  = 1'b0;
                    finish  = 1'b1;
                end else begin
                    state_n = SHIFT_HI;
                    sclk_n  = 1'b1;
                    shift_n = {shift[FRAME_BITS-2:0], bus.spi_miso};
                end
            end
            DONE: begin
                if (ch == CW'(CHANNELS - 1)) begin
                    ch_n    = '0;
                    idle_n  = IW'(INTERVAL);
                    state_n = IDLE;
                end else begin
                    ch_n    = ch + 1'b1;
                    state_n = GAP;
                end
            end
            GAP: begin
                state_n = SELECT;
                cs_n    = ~sel;
                sclk_n  = 1'b0;
                bit_n   = '0;
                busy_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= TW'(DIVIDER - 1);
            state    <= IDLE;
            ch       <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            idle_cnt <= '0;
            sclk     <= 1'b0;
            cs       <= '1;
            busy     <= 1'b0;
        end else begin
            tick_cnt <= tick ? TW'(DIVIDER - 1) : tick_cnt - 1'b1;
            if (tick) begin
                state    <= state_n;
                ch       <= ch_n;
                bit_cnt  <= bit_n;
                shift    <= shift_n;
                idle_cnt <= idle_n;
                sclk     <= sclk_n;
                cs       <= cs_n;
                busy     <= busy_n;
            end
        end
    end

    // Temperature holds its last good reading across faulted frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            temperature <= '0;
            fault       <= '0;
            valid       <= '0;
        end else begin
            valid <= '0;
            if (tick && finish) begin
                valid <= sel;
                fault <= (fault & ~sel) | (dec_fault ? sel : '0);
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    if (sel[i] && !dec_fault) begin
                        temperature[32*i +: 32] <= dec_raw;
                    end
                end
            end
        end
    end

    assign bus.spi_sclk    = sclk;
    assign bus.spi_cs      = cs;
    assign bus.busy        = busy;
    assign bus.temperature = temperature;
    assign bus.fault       = fault;
    assign bus.valid       = valid;
endmodule
